// File: rtl/cic_decimator.sv
// cic_decimator: N-stage CIC decimator (clk, rst sync high; in_valid/in_data samples in; out_valid strobe, out_data held decimated result)
module cic_decimator #(
  parameter int IN_WIDTH   = 16,
  parameter int STAGES     = 3,
  parameter int RATE       = 8,
  parameter int DIFF_DELAY = 1,
  parameter int OUT_WIDTH  = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data
);
  localparam int W  = IN_WIDTH + STAGES * $clog2(RATE * DIFF_DELAY);
  localparam int CW = $clog2(RATE);
  logic [W-1:0]  x;
  logic [CW-1:0] cnt;
  logic          last;
  logic [W-1:0]  dec_data;
  logic          dec_v;
  assign x    = {{(W-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
  assign last = cnt == CW'(RATE - 1);
  for (genvar k = 0; k < STAGES; k++) begin : s
    logic [W-1:0] acc, sum;
    if (k == 0) begin : h
      assign sum = acc + x;
    end else begin : h
      assign sum = acc + s[k-1].sum;
    end
    always_ff @(posedge clk)
      if (rst) acc <= '0;
      else if (in_valid) acc <= sum;
  end
  always_ff @(posedge clk)
    if (rst) begin
      cnt      <= '0;
      dec_v    <= 1'b0;
      dec_data <= '0;
    end else begin
      dec_v <= in_valid && last;
      if (in_valid) cnt <= last ? '0 : cnt + 1'b1;
      if (in_valid && last) dec_data <= s[STAGES-1].sum;
    end
  for (genvar k = 0; k < STAGES; k++) begin : c
    logic [W-1:0] y, xi;
    logic         v, vi;
    logic [W-1:0] dl [DIFF_DELAY];
    if (k == 0) begin : h
      assign xi = dec_data;
      assign vi = dec_v;
    end else begin : h
      assign xi = c[k-1].y;
      assign vi = c[k-1].v;
    end
    always_ff @(posedge clk)
      if (rst) begin
        y <= '0;
        v <= 1'b0;
        for (int j = 0; j < DIFF_DELAY; j++) dl[j] <= '0;
      end else begin
        v <= vi;
        if (vi) begin
          y     <= xi - dl[DIFF_DELAY-1];
          dl[0] <= xi;
          for (int j = 1; j < DIFF_DELAY; j++) dl[j] <= dl[j-1];
        end
      end
  end
  assign out_valid = c[STAGES-1].v;
  assign out_data  = c[STAGES-1].y[W-1 -: OUT_WIDTH];
endmodule
